// File: rtl/sprite_pos_fetch.sv
// Once per frame, fetches the six sprite coordinates from memory port A and
// commits them together, so vga never sees a half-updated set of positions.
module sprite_pos_fetch #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MXP   = WIDTH'(6000),
  parameter logic [WIDTH-1:0] MYP   = WIDTH'(6004),
  parameter logic [WIDTH-1:0] P1XP  = WIDTH'(6008),
  parameter logic [WIDTH-1:0] P1YP  = WIDTH'(6012),
  parameter logic [WIDTH-1:0] P2XP  = WIDTH'(6016),
  parameter logic [WIDTH-1:0] P2YP  = WIDTH'(6020)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mx,
  output logic [WIDTH-1:0] my,
  output logic [WIDTH-1:0] p1x,
  output logic [WIDTH-1:0] p1y,
  output logic [WIDTH-1:0] p2x,
  output logic [WIDTH-1:0] p2y,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q [6];
  logic [WIDTH-1:0] coord_q  [6];
  logic             done_q;

  function automatic logic [WIDTH-1:0] addr_of(input logic [2:0] idx);
    case (idx)
      3'd0:    addr_of = MXP;
      3'd1:    addr_of = MYP;
      3'd2:    addr_of = P1XP;
      3'd3:    addr_of = P1YP;
      3'd4:    addr_of = P2XP;
      default: addr_of = P2YP;
    endcase
  endfunction

  // frame_start is a request pulse honoured only in IDLE (never queued);
  // done is a one-cycle pulse marking the cycle the new snapshot is visible.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mem_addr = MXP;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FETCH;
          idx_d   = 3'd0;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        mem_addr = addr_of(idx_q);
        if (idx_q == 3'd5) state_d = DRAIN;
        else               idx_d   = idx_q + 3'd1;
      end
      DRAIN: begin
        busy     = 1'b1;
        mem_addr = P2YP;
        state_d  = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
        coord_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= (state_q == COMMIT);
      // Read data lags its address by one cycle, hence the idx-1 slot.
      if (state_q == FETCH) begin
        for (int i = 0; i < 5; i++) begin
          if (idx_q == 3'(i + 1)) shadow_q[i] <= mem_data;
        end
      end
      if (state_q == DRAIN) shadow_q[5] <= mem_data;
      if (state_q == COMMIT) begin
        for (int i = 0; i < 6; i++) coord_q[i] <= shadow_q[i];
      end
    end
  end

  assign mx        = coord_q[0];
  assign my        = coord_q[1];
  assign p1x       = coord_q[2];
  assign p1y       = coord_q[3];
  assign p2x       = coord_q[4];
  assign p2y       = coord_q[5];
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sprite_pos_fetch.sv
// Directed bench for sprite_pos_fetch: address sequence, atomic commit,
// ignored collisions, reset mid-fetch and back-to-back frames.
module tb_sprite_pos_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [15:0] mem_data;
  logic [15:0] mem_addr;
  logic [15:0] mx, my, p1x, p1y, p2x, p2y;
  logic        busy, done;
  logic [1:0]  state_dbg;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_q[$];
  logic [15:0] exp_coord [6];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_n, done_n;

  sprite_pos_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .mem_data    (mem_data),
    .mem_addr    (mem_addr),
    .mx          (mx),
    .my          (my),
    .p1x         (p1x),
    .p1y         (p1y),
    .p2x         (p2x),
    .p2y         (p2y),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // clock / memory port A model (synchronous read, 1-cycle latency)
  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input int base);
    for (int i = 0; i < 6; i++) mem[6000 + 4 * i] = 16'(base * (i + 1));
  endtask

  task automatic set_exp(input logic [15:0] a, b, c, d, e, f);
    exp_coord[0] = a; exp_coord[1] = b; exp_coord[2] = c;
    exp_coord[3] = d; exp_coord[4] = e; exp_coord[5] = f;
  endtask

  task automatic check_coords(input string tag);
    check({tag, "_mx"},  mx,  exp_coord[0]);
    check({tag, "_my"},  my,  exp_coord[1]);
    check({tag, "_p1x"}, p1x, exp_coord[2]);
    check({tag, "_p1y"}, p1y, exp_coord[3]);
    check({tag, "_p2x"}, p2x, exp_coord[4]);
    check({tag, "_p2y"}, p2y, exp_coord[5]);
  endtask

  // Driver: pulse frame_start, then watch cycles k=0..8 after acceptance.
  // Optional second pulse at cycle pulse_k and port-B write at write_k.
  task automatic fetch_frame(input string tag, input int pulse_k, input int write_k,
                             input logic [15:0] wdata, input logic [15:0] hold_mx);
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(6000 + 4 * i));
    busy_n = 0;
    done_n = 0;
    frame_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      frame_start = (k == pulse_k);
      if (k == write_k) mem[6000] = wdata;
      busy_n += int'(busy);
      done_n += int'(done);
      if (k < 6)  check({tag, "_addr"}, mem_addr, exp_q.pop_front());
      if (k == 6) check({tag, "_drain_addr"}, mem_addr, 16'd6020);
      if (k < 8)  check({tag, "_mx_hold"}, mx, hold_mx);
      if (k == 8) begin
        check({tag, "_done"}, {15'd0, done}, 16'd1);
        check_coords(tag);
      end
      @(negedge clk);
    end
    frame_start = 1'b0;
    check({tag, "_busy_len"}, 16'(busy_n), 16'd8);
    check({tag, "_done_cnt"}, 16'(done_n), 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 24; i++) mem[6000 + i] = '0;
    reset = 1'b1;
    frame_start = 1'b0;

    // reset
    @(negedge clk);
    @(negedge clk);
    set_exp(0, 0, 0, 0, 0, 0);
    check_coords("rst");
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_addr", mem_addr, 16'd6000);
    check("rst_state", {14'd0, state_dbg}, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // basic fetch
    set_mem(100);
    set_exp(100, 200, 300, 400, 500, 600);
    fetch_frame("basic", -1, -1, 16'd0, 16'd0);
    check("basic_done_drop", {15'd0, done}, 16'd0);

    // atomicity: port-B write after mx address was sampled
    fetch_frame("atom1", -1, 3, 16'd111, 16'd100);
    set_exp(111, 200, 300, 400, 500, 600);
    fetch_frame("atom2", -1, -1, 16'd0, 16'd100);

    // busy collision: extra pulse while busy is dropped
    fetch_frame("coll", 2, -1, 16'd0, 16'd111);
    check("coll_idle_busy", {15'd0, busy}, 16'd0);

    // reset in DRAIN: no partial commit
    set_mem(7);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    check("mid_in_drain", {14'd0, state_dbg}, 16'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0);
    check_coords("mid_rst");
    check("mid_state", {14'd0, state_dbg}, 16'd0);
    check("mid_busy", {15'd0, busy}, 16'd0);
    check("mid_addr", mem_addr, 16'd6000);
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("mid_no_done", {15'd0, done}, 16'd0);
    check("mid_mx_still0", mx, 16'd0);
    set_exp(7, 14, 21, 28, 35, 42);
    fetch_frame("mid_refetch", -1, -1, 16'd0, 16'd0);

    // back-to-back: pulse in the done cycle
    set_mem(21);
    set_exp(21, 42, 63, 84, 105, 126);
    fetch_frame("b2b1", 8, -1, 16'd0, 16'd7);
    check("b2b_addr", mem_addr, 16'd6000);
    check("b2b_busy", {15'd0, busy}, 16'd1);
    check("b2b_done_low", {15'd0, done}, 16'd0);
    for (int k = 0; k < 8; k++) @(negedge clk);
    check("b2b2_done", {15'd0, done}, 16'd1);
    check_coords("b2b2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
